// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths, fixed register numbers and writeback requester indices.
package cpu_pkg;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int LINK_REG = 31;
    localparam int OVF_REG  = 30;
    localparam int NREQ     = 3;

    typedef enum logic [1:0] {
        REQ_WB = 2'd0,
        REQ_LK = 2'd1,
        REQ_OV = 2'd2
    } req_e;
endpackage

// File: rtl/gpr_wr_slot.sv
// One-entry holding register for a writeback requester with a saturating
// lost-arbitration counter used to age the entry.
module gpr_wr_slot #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 3,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_load,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_grant,
    output logic          o_hold_v,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_aged
);
    logic          r_hold_v;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_wait;

    // A load in the same cycle as a grant replaces the departing entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_v <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_wait   <= '0;
        end else if (i_flush) begin
            r_hold_v <= 1'b0;
            r_wait   <= '0;
        end else if (i_load) begin
            r_hold_v <= 1'b1;
            r_addr   <= i_addr;
            r_data   <= i_data;
            r_wait   <= '0;
        end else if (i_grant || !r_hold_v) begin
            r_hold_v <= 1'b0;
            r_wait   <= '0;
        end else if (r_wait != CW'(MAX_WAIT)) begin
            r_wait <= r_wait + CW'(1);
        end
    end

    assign o_hold_v = r_hold_v;
    assign o_addr   = r_addr;
    assign o_data   = r_data;
    assign o_aged   = r_hold_v && (r_wait == CW'(MAX_WAIT));
endmodule

// File: rtl/gpr_wr_arbiter.sv
// Shares the GPR write port among main writeback, jal link and overflow-flag
// requesters using fixed priority (wb > lk > ov) with aging promotion.
module gpr_wr_arbiter
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wb_v,
    output logic          wb_rdy,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          lk_v,
    output logic          lk_rdy,
    input  logic [DW-1:0] lk_data,
    input  logic          ov_v,
    output logic          ov_rdy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [31:0]   pend_mask,
    output logic          idle
);
    logic [NREQ-1:0] w_in_v;
    logic [AW-1:0]   w_in_addr [NREQ];
    logic [DW-1:0]   w_in_data [NREQ];
    logic [NREQ-1:0] w_rdy;
    logic [NREQ-1:0] w_load;
    logic [NREQ-1:0] w_hold_v;
    logic [NREQ-1:0] w_aged;
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_grant;
    logic [AW-1:0]   w_addr [NREQ];
    logic [DW-1:0]   w_data [NREQ];

    always_comb begin
        w_in_v                 = '0;
        w_in_v[int'(REQ_WB)]   = wb_v;
        w_in_v[int'(REQ_LK)]   = lk_v;
        w_in_v[int'(REQ_OV)]   = ov_v;
        w_in_addr[int'(REQ_WB)] = wb_addr;
        w_in_addr[int'(REQ_LK)] = AW'(LINK_REG);
        w_in_addr[int'(REQ_OV)] = AW'(OVF_REG);
        w_in_data[int'(REQ_WB)] = wb_data;
        w_in_data[int'(REQ_LK)] = lk_data;
        w_in_data[int'(REQ_OV)] = DW'(1);
    end

    // Writes to $0 complete the handshake but are never held.
    assign w_rdy  = {NREQ{!flush}} & (~w_hold_v | w_grant);
    assign w_load = w_in_v & w_rdy;

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        gpr_wr_slot #(
            .DW       (DW),
            .AW       (AW),
            .MAX_WAIT (MAX_WAIT)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .i_flush  (flush),
            .i_load   (w_load[g] && (w_in_addr[g] != '0)),
            .i_addr   (w_in_addr[g]),
            .i_data   (w_in_data[g]),
            .i_grant  (w_grant[g]),
            .o_hold_v (w_hold_v[g]),
            .o_addr   (w_addr[g]),
            .o_data   (w_data[g]),
            .o_aged   (w_aged[g])
        );
    end

    // Lowest set bit of the candidate set is the highest base priority.
    assign w_cand  = (|w_aged) ? w_aged : w_hold_v;
    assign w_grant = w_cand & (~w_cand + NREQ'(1));

    always_comb begin
        wr_addr   = '0;
        wr_data   = '0;
        pend_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                wr_addr = w_addr[i];
                wr_data = w_data[i];
            end
            if (w_hold_v[i]) begin
                pend_mask = pend_mask | (32'd1 << w_addr[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

    assign wr_en  = |w_grant;
    assign idle   = ~|w_hold_v;
    assign wb_rdy = w_rdy[int'(REQ_WB)];
    assign lk_rdy = w_rdy[int'(REQ_LK)];
    assign ov_rdy = w_rdy[int'(REQ_OV)];
endmodule
